// File: rtl/perm_check_pkg.sv
// Shared types and constants for the S-array permutation checker.
package perm_check_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, REPORT} state_t;

  localparam int          ADDR_W_DEF = 8;
  localparam int          DEPTH      = 2**ADDR_W_DEF;
  localparam logic [15:0] PERM_SUM   = 16'h7F80;
endpackage

// File: rtl/perm_check_if.sv
// Start handshake, S-memory read port and result bus of perm_check.
// PERM_CHECK_SUM_EN adds the 16-bit byte-sum result.
interface perm_check_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              en;
  logic              rdy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rddata;
  logic              res_valid;
  logic              is_perm;
  logic              is_ident;
  logic [ADDR_W-1:0] dup_addr;
`ifdef PERM_CHECK_SUM_EN
  logic [15:0]       sum;

  modport master (output en, rddata,
                  input  rdy, addr, res_valid, is_perm, is_ident, dup_addr, sum);
  modport slave  (input  en, rddata,
                  output rdy, addr, res_valid, is_perm, is_ident, dup_addr, sum);
`else
  modport master (output en, rddata,
                  input  rdy, addr, res_valid, is_perm, is_ident, dup_addr);
  modport slave  (input  en, rddata,
                  output rdy, addr, res_valid, is_perm, is_ident, dup_addr);
`endif
endinterface

// File: rtl/perm_check_rd_tag_pipe.sv
// Delays {valid, tag} by the memory read latency so each tag meets its rddata.
module rd_tag_pipe #(
  parameter int LAT = 1,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_tag,
  output logic         out_vld,
  output logic [W-1:0] out_tag
);
  logic [LAT:1]        vld_pipe;
  logic [LAT:1][W-1:0] tag_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      tag_pipe[1] <= in_tag;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign out_vld = vld_pipe[LAT];
  assign out_tag = tag_pipe[LAT];
endmodule

// File: rtl/perm_check.sv
// Scans the S memory and reports permutation / identity / first duplicate.
// PERM_CHECK_SUM_EN adds a modulo-2^16 sum of all bytes read.
module perm_check
  import perm_check_pkg::*;
#(
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  perm_check_if.slave io
);
  state_t              state;
  logic                rdy_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [2:0]          drain_cnt;
  logic [2**ADDR_W-1:0] seen;
  logic                dup_r;
  logic                ident_r;
  logic [ADDR_W-1:0]   dup_addr_r;
  logic                res_valid_r;
  logic                is_perm_r;
  logic                is_ident_r;
  logic [ADDR_W-1:0]   dup_addr_o;

  logic                out_vld;
  logic [ADDR_W-1:0]   out_tag;
  logic [DATA_W-1:0]   word;

  rd_tag_pipe #(.LAT(RD_LAT), .W(ADDR_W)) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vld (state == READ),
    .in_tag (addr_r),
    .out_vld(out_vld),
    .out_tag(out_tag)
  );

  assign word = io.rddata;

  // Next-state of the scan flags including the word retiring this cycle, so the
  // report edge can publish a result that already accounts for the last word.
  logic              word_dup;
  logic              dup_nxt;
  logic              ident_nxt;
  logic [ADDR_W-1:0] dup_addr_nxt;

  always_comb begin
    word_dup     = out_vld && seen[word];
    dup_nxt      = dup_r | word_dup;
    dup_addr_nxt = (word_dup && !dup_r) ? out_tag : dup_addr_r;
    ident_nxt    = ident_r & ~(out_vld && (word != out_tag));
  end

`ifdef PERM_CHECK_SUM_EN
  logic [15:0] sum_acc;
  logic [15:0] sum_nxt;
  logic [15:0] sum_r;

  assign sum_nxt = sum_acc + (out_vld ? 16'(word) : 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc <= '0;
      sum_r   <= '0;
    end else if (state == IDLE && io.en) begin
      sum_acc <= '0;
    end else begin
      sum_acc <= sum_nxt;
      if (state == DRAIN && drain_cnt == 3'(RD_LAT-1))
        sum_r <= sum_nxt;
    end
  end

  assign io.sum = sum_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rdy_r       <= 1'b1;
      addr_r      <= '0;
      drain_cnt   <= '0;
      seen        <= '0;
      dup_r       <= 1'b0;
      ident_r     <= 1'b0;
      dup_addr_r  <= '0;
      res_valid_r <= 1'b0;
      is_perm_r   <= 1'b0;
      is_ident_r  <= 1'b0;
      dup_addr_o  <= '0;
    end else begin
      res_valid_r <= 1'b0;
      if (out_vld) begin
        seen[word] <= 1'b1;
        dup_r      <= dup_nxt;
        dup_addr_r <= dup_addr_nxt;
        ident_r    <= ident_nxt;
      end
      case (state)
        IDLE: if (io.en) begin
          state      <= READ;
          rdy_r      <= 1'b0;
          addr_r     <= '0;
          seen       <= '0;
          dup_r      <= 1'b0;
          ident_r    <= 1'b1;
          dup_addr_r <= '0;
        end
        READ: if (addr_r == '1) begin
          state     <= DRAIN;
          drain_cnt <= '0;
        end else begin
          addr_r <= addr_r + 1'b1;
        end
        DRAIN: if (drain_cnt == 3'(RD_LAT-1)) begin
          state       <= REPORT;
          res_valid_r <= 1'b1;
          is_perm_r   <= !dup_nxt;
          is_ident_r  <= ident_nxt && !dup_nxt;
          dup_addr_o  <= dup_addr_nxt;
        end else begin
          drain_cnt <= drain_cnt + 3'd1;
        end
        REPORT: begin
          state  <= IDLE;
          rdy_r  <= 1'b1;
          addr_r <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.rdy       = rdy_r;
  assign io.addr      = addr_r;
  assign io.res_valid = res_valid_r;
  assign io.is_perm   = is_perm_r;
  assign io.is_ident  = is_ident_r;
  assign io.dup_addr  = dup_addr_o;
endmodule

// File: tb/tb_perm_check.sv
// Directed bench for perm_check: one RD_LAT=1 instance for result checks,
// one RD_LAT=2 instance for back-to-back scans.
module tb_perm_check;
  import perm_check_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  perm_check_if #(.ADDR_W(8), .DATA_W(8)) io1 ();
  perm_check_if #(.ADDR_W(8), .DATA_W(8)) io2 ();

  perm_check #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io(io1));
  perm_check #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .io(io2));

  logic [7:0] mem [256];
  logic [7:0] rd1, rd2a, rd2b;

  always_ff @(posedge clk) begin
    rd1  <= mem[io1.addr];
    rd2a <= mem[io2.addr];
    rd2b <= rd2a;
  end
  assign io1.rddata = rd1;
  assign io2.rddata = rd2b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_ident();
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
  endtask

  // Pulse en on io1 and return the cycle (1 = first cycle after the en edge)
  // in which res_valid is seen; optionally re-pulse en at cycle poke.
  task automatic scan1(input int poke, output int lat);
    lat = 0;
    @(negedge clk);
    io1.en = 1'b1;
    @(negedge clk);
    io1.en = 1'b0;
    chk("rdy_busy", 32'(io1.rdy), 32'd0);
    for (int c = 1; c < 400; c++) begin
      if (c > 1) @(negedge clk);
      io1.en = (c == poke);
      if (io1.res_valid) begin
        lat = c;
        break;
      end
    end
    io1.en = 1'b0;
  endtask

  int lat;
  int nres;
  int t [3];
  int t_start;
  bit hit;

  initial begin
    rst_n  = 1'b0;
    io1.en = 1'b0;
    io2.en = 1'b0;
    fill_ident();
    repeat (3) @(negedge clk);
    chk("rst_rdy",      32'(io1.rdy),       32'd1);
    chk("rst_addr",     32'(io1.addr),      32'd0);
    chk("rst_valid",    32'(io1.res_valid), 32'd0);
    chk("rst_perm",     32'(io1.is_perm),   32'd0);
    chk("rst_ident",    32'(io1.is_ident),  32'd0);
    chk("rst_dup",      32'(io1.dup_addr),  32'd0);
`ifdef PERM_CHECK_SUM_EN
    chk("rst_sum",      32'(io1.sum),       32'd0);
`endif
    rst_n = 1'b1;

    // identity memory
    scan1(0, lat);
    chk("id_lat",   32'(lat),          32'd258);
    chk("id_perm",  32'(io1.is_perm),  32'd1);
    chk("id_ident", 32'(io1.is_ident), 32'd1);
    chk("id_dup",   32'(io1.dup_addr), 32'd0);
`ifdef PERM_CHECK_SUM_EN
    chk("id_sum",   32'(io1.sum),      32'(PERM_SUM));
`endif
    @(negedge clk);
    chk("id_rdy_after",   32'(io1.rdy),       32'd1);
    chk("id_valid_pulse", 32'(io1.res_valid), 32'd0);

    // reversed memory, stray en mid-scan must be ignored
    for (int a = 0; a < 256; a++) mem[a] = 8'(255 - a);
    scan1(10, lat);
    chk("rev_lat",   32'(lat),          32'd258);
    chk("rev_perm",  32'(io1.is_perm),  32'd1);
    chk("rev_ident", 32'(io1.is_ident), 32'd0);
    chk("rev_dup",   32'(io1.dup_addr), 32'd0);
    repeat (3) @(negedge clk);
    chk("rev_no_queue", 32'(io1.rdy), 32'd1);

    // single duplicate at 200
    fill_ident();
    mem[200] = 8'h05;
    scan1(0, lat);
    chk("d200_lat",   32'(lat),          32'd258);
    chk("d200_perm",  32'(io1.is_perm),  32'd0);
    chk("d200_ident", 32'(io1.is_ident), 32'd0);
    chk("d200_dup",   32'(io1.dup_addr), 32'd200);
`ifdef PERM_CHECK_SUM_EN
    chk("d200_sum",   32'(io1.sum),      32'h7EBD);
`endif

    // three copies of 7: first duplicate reported only
    fill_ident();
    mem[5] = 8'h07; mem[7] = 8'h05; mem[200] = 8'h07; mem[250] = 8'h07;
    scan1(0, lat);
    chk("d3_perm", 32'(io1.is_perm),  32'd0);
    chk("d3_dup",  32'(io1.dup_addr), 32'd200);
`ifdef PERM_CHECK_SUM_EN
    chk("d3_sum",  32'(io1.sum),      32'h7DCC);
`endif

    // reset at addr==100 aborts the scan
    fill_ident();
    @(negedge clk); io1.en = 1'b1;
    @(negedge clk); io1.en = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (io1.addr == 8'd100) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_reach100", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy",  32'(io1.rdy),     32'd1);
    chk("abort_addr", 32'(io1.addr),    32'd0);
    chk("abort_perm", 32'(io1.is_perm), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nres = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (io1.res_valid) nres++;
    end
    chk("abort_no_valid", 32'(nres), 32'd0);
    scan1(0, lat);
    chk("fresh_lat",   32'(lat),          32'd258);
    chk("fresh_perm",  32'(io1.is_perm),  32'd1);
    chk("fresh_ident", 32'(io1.is_ident), 32'd1);

    // back-to-back scans on the RD_LAT=2 instance
    @(negedge clk);
    io2.en  = 1'b1;
    t_start = cyc;
    nres    = 0;
    for (int c = 0; c < 1000 && nres < 3; c++) begin
      @(negedge clk);
      if (io2.res_valid) begin
        t[nres] = cyc;
        chk("b2b_perm",  32'(io2.is_perm),  32'd1);
        chk("b2b_ident", 32'(io2.is_ident), 32'd1);
`ifdef PERM_CHECK_SUM_EN
        chk("b2b_sum",   32'(io2.sum),      32'(PERM_SUM));
`endif
        nres++;
      end
    end
    io2.en = 1'b0;
    chk("b2b_count", 32'(nres), 32'd3);
    if (nres == 3) begin
      chk("b2b_first",   32'(t[0] - t_start), 32'd259);
      chk("b2b_period1", 32'(t[1] - t[0]),    32'd260);
      chk("b2b_period2", 32'(t[2] - t[1]),    32'd260);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
